mul_share_arb: RTL and testbench

- Shares one W x W unsigned multiplier between two requesters (client 0, client 1).
- Round-robin arbitration, operand capture, multi-cycle compute sequencing, and a single registered response channel tagged with the client id.
- Sits between client FSMs and the multiplier datapath. The product is full width, 2*W bits, so it never overflows (255*255 = 65025 fits in 16 bits).

---
 rtl/mul_share_arb.sv | 125 ++++++++++++
 tb/tb_mul_share_arb.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arb.sv
// mul_share_arb: round-robin front end sharing one W x W unsigned multiplier between two clients.
// Optional macro MUL_ARB_STATS_EN adds 16-bit per-client grant counters (grant_cnt0/grant_cnt1).
//
// state | meaning
// IDLE  | no operation in flight; ready driven toward the arbitration winner
// BUSY  | operands captured, latency down-counter running
// RESP  | product presented on rsp_* until the consumer takes it
module mul_share_arb #(
  parameter int W   = 8,
  parameter int LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  output logic           req0_ready,
  input  logic           req1_valid,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  output logic           req1_ready,
  output logic           rsp_valid,
  output logic           rsp_id,
  output logic [2*W-1:0] rsp_data,
  input  logic           rsp_ready,
  output logic           busy
`ifdef MUL_ARB_STATS_EN
  ,
  output logic [15:0]    grant_cnt0,
  output logic [15:0]    grant_cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic           id_q;
  logic           last_grant;
  logic [3:0]     cnt_q;
  logic           grant_any;
  logic           grant_id;
  logic           accept;
  logic [W-1:0]   grant_a;
  logic [W-1:0]   grant_b;
  logic [2*W-1:0] prod;

  // On a tie the client that did not win last time is served.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    if (req0_valid && req1_valid) grant_id = ~last_grant;
    else                          grant_id = req1_valid;
  end

  assign req0_ready = rst_n && (state == IDLE) && grant_any && !grant_id;
  assign req1_ready = rst_n && (state == IDLE) && grant_any && grant_id;
  assign accept     = req0_ready | req1_ready;
  assign grant_a    = grant_id ? req1_a : req0_a;
  assign grant_b    = grant_id ? req1_b : req0_b;
  assign prod       = (2*W)'(a_q) * (2*W)'(b_q);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      last_grant <= 1'b1;
      cnt_q      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q        <= grant_a;
            b_q        <= grant_b;
            id_q       <= grant_id;
            last_grant <= grant_id;
            cnt_q      <= 4'(LAT - 1);
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q == 4'd0) begin
            rsp_data  <= prod;
            rsp_id    <= id_q;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          // rsp_data is deliberately left holding the last product.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MUL_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (req0_ready) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (req1_ready) grant_cnt1 <= grant_cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mul_share_arb.sv
// Self-checking bench for mul_share_arb: a LAT=1 instance and a LAT=4 instance share stimulus.
// Build with MUL_ARB_STATS_EN defined to also check the grant counters.
module tb_mul_share_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, rsp_ready;
  logic [7:0]  req0_a, req0_b, req1_a, req1_b;

  logic        r0_1, r1_1, rv_1, rid_1, busy_1;
  logic [15:0] rd_1;
  logic        r0_4, r1_4, rv_4, rid_4, busy_4;
  logic [15:0] rd_4;
`ifdef MUL_ARB_STATS_EN
  logic [15:0] gc0_1, gc1_1, gc0_4, gc1_4;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mul_share_arb #(.W(8), .LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(r0_1),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(r1_1),
    .rsp_valid(rv_1), .rsp_id(rid_1), .rsp_data(rd_1), .rsp_ready(rsp_ready),
    .busy(busy_1)
`ifdef MUL_ARB_STATS_EN
    , .grant_cnt0(gc0_1), .grant_cnt1(gc1_1)
`endif
  );

  mul_share_arb #(.W(8), .LAT(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(r0_4),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(r1_4),
    .rsp_valid(rv_4), .rsp_id(rid_4), .rsp_data(rd_4), .rsp_ready(rsp_ready),
    .busy(busy_4)
`ifdef MUL_ARB_STATS_EN
    , .grant_cnt0(gc0_4), .grant_cnt1(gc1_4)
`endif
  );

  task automatic do_reset();
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Returns the number of edges after the accept edge until rsp_valid (dut1), or -1.
  task automatic wait_rsp1(output int n);
    n = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rv_1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run_op(input logic id, input logic [7:0] a, input logic [7:0] b,
                        output logic rdy, output logic gid, output logic [15:0] gdata,
                        output int lat);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    @(negedge clk);
    rdy = id ? r1_1 : r0_1;
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_rsp1(lat);
    gid   = rid_1;
    gdata = rd_1;
    @(posedge clk);
  endtask

  task automatic test_reset();
    logic [20:0] obs;
    rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b0;
    req0_a = 8'd1; req0_b = 8'd1; req1_a = 8'd2; req1_b = 8'd2;
    #3;
    obs = {r0_1, r1_1, rv_1, rid_1, busy_1, rd_1};
    n_tests++;
    if (obs !== 21'd0) begin
      n_fail++; $display("FAIL reset_outputs got=%h want=0", obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++;
    if ({r0_1, r1_1} !== 2'b10) begin
      n_fail++; $display("FAIL first_tie_grant got=%b want=10", {r0_1, r1_1});
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
`ifdef MUL_ARB_STATS_EN
    n_tests++;
    if ({gc0_1, gc1_1} !== 32'd0) begin
      n_fail++; $display("FAIL reset_stats got=%h want=0", {gc0_1, gc1_1});
    end
`endif
  endtask

  task automatic test_max_operands();
    logic rdy, gid; logic [15:0] gd; int lat;
    run_op(1'b0, 8'd255, 8'd255, rdy, gid, gd, lat);
    n_tests++;
    if (rdy !== 1'b1) begin n_fail++; $display("FAIL max_ready got=%b want=1", rdy); end
    n_tests++;
    if (lat !== 1) begin n_fail++; $display("FAIL max_latency got=%0d want=1", lat); end
    n_tests++;
    if ({gid, gd} !== {1'b0, 16'd65025}) begin
      n_fail++; $display("FAIL max_product got id=%b data=%0d want id=0 data=65025", gid, gd);
    end
  endtask

  task automatic test_zero_identity();
    logic rdy, gid; logic [15:0] gd; int lat;
    run_op(1'b1, 8'd0, 8'd200, rdy, gid, gd, lat);
    n_tests++;
    if ({rdy, gid, gd} !== {1'b1, 1'b1, 16'd0} || lat !== 1) begin
      n_fail++; $display("FAIL zero_operand got rdy=%b id=%b data=%0d lat=%0d want 1 1 0 1", rdy, gid, gd, lat);
    end
    run_op(1'b1, 8'd1, 8'd173, rdy, gid, gd, lat);
    n_tests++;
    if ({rdy, gid, gd} !== {1'b1, 1'b1, 16'd173} || lat !== 1) begin
      n_fail++; $display("FAIL identity_operand got rdy=%b id=%b data=%0d lat=%0d want 1 1 173 1", rdy, gid, gd, lat);
    end
  endtask

  task automatic test_round_robin();
    logic m_last = 1'b1;
    logic exp_id;
    int n;
    do_reset();
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 8'd3; req0_b = 8'd4;
    req1_valid = 1'b1; req1_a = 8'd5; req1_b = 8'd6;
    for (int k = 0; k < 4; k++) begin
      exp_id = ~m_last;
      m_last = exp_id;
      wait_rsp1(n);
      n_tests++;
      if (n < 0) begin
        n_fail++; $display("FAIL rr_timeout op=%0d got no response want response", k);
      end else if ({rid_1, rd_1} !== {exp_id, exp_id ? 16'd30 : 16'd12}) begin
        n_fail++; $display("FAIL rr_grant op=%0d got id=%b data=%0d want id=%b data=%0d",
                           k, rid_1, rd_1, exp_id, exp_id ? 30 : 12);
      end
      @(posedge clk);
    end
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int n;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 8'd9; req0_b = 8'd7;
    req1_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (r0_1 !== 1'b1) begin n_fail++; $display("FAIL bp_accept got=%b want=1", r0_1); end
    @(posedge clk); #1;
    req1_valid = 1'b1;
    req0_a = 8'($urandom_range(0, 255)); req1_a = 8'($urandom_range(0, 255));
    wait_rsp1(n);
    n_tests++;
    if (n != 1) begin n_fail++; $display("FAIL bp_latency got=%0d want=1", n); end
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if ({rv_1, rid_1, rd_1, r0_1, r1_1, busy_1} !== {1'b1, 1'b0, 16'd63, 1'b0, 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL bp_hold cyc=%0d got v=%b id=%b data=%0d rdy=%b%b busy=%b want v=1 id=0 data=63 rdy=00 busy=1",
                 i, rv_1, rid_1, rd_1, r0_1, r1_1, busy_1);
      end
      @(posedge clk); #1;
      req0_a = 8'($urandom_range(0, 255)); req0_b = 8'($urandom_range(0, 255));
      req1_a = 8'($urandom_range(0, 255)); req1_b = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 8'd2; req1_b = 8'd3;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({busy_1, rv_1, r1_1, rd_1} !== {1'b0, 1'b0, 1'b1, 16'd63}) begin
      n_fail++; $display("FAIL bp_release got busy=%b v=%b rdy1=%b data=%0d want 0 0 1 63",
                         busy_1, rv_1, r1_1, rd_1);
    end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_rsp1(n);
    n_tests++;
    if (n != 1 || {rid_1, rd_1} !== {1'b1, 16'd6}) begin
      n_fail++; $display("FAIL bp_next_op got lat=%0d id=%b data=%0d want 1 1 6", n, rid_1, rd_1);
    end
    @(posedge clk);
  endtask

  task automatic test_lat4();
    do_reset();
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 8'd17; req0_b = 8'd15;
    @(negedge clk);
    n_tests++;
    if (r0_4 !== 1'b1) begin n_fail++; $display("FAIL lat4_accept got=%b want=1", r0_4); end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      n_tests++;
      if ({rv_4, busy_4} !== 2'b01) begin
        n_fail++; $display("FAIL lat4_early edge=k+%0d got v=%b busy=%b want v=0 busy=1", j, rv_4, busy_4);
      end
    end
    @(negedge clk);
    n_tests++;
    if ({rv_4, rid_4, rd_4} !== {1'b1, 1'b0, 16'd255}) begin
      n_fail++; $display("FAIL lat4_rsp got v=%b id=%b data=%0d want 1 0 255", rv_4, rid_4, rd_4);
    end
    @(posedge clk);
  endtask

  task automatic test_reset_mid_busy();
    logic seen = 1'b0;
    do_reset();
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 8'd10; req0_b = 8'd10;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({busy_1, busy_4} !== 2'b11) begin
      n_fail++; $display("FAIL midrst_pre got busy=%b%b want 11", busy_1, busy_4);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({rv_1, busy_1, rv_4, busy_4, rd_1, rd_4} !== 36'd0) begin
      n_fail++; $display("FAIL midrst_outputs got v=%b%b busy=%b%b data=%0d/%0d want all 0",
                         rv_1, rv_4, busy_1, busy_4, rd_1, rd_4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rv_1 || rv_4 || busy_1 || busy_4) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_stale got activity=1 want 0"); end
`ifdef MUL_ARB_STATS_EN
    n_tests++;
    if ({gc0_1, gc1_1, gc0_4, gc1_4} !== 64'd0) begin
      n_fail++; $display("FAIL midrst_stats got %0d %0d %0d %0d want 0", gc0_1, gc1_1, gc0_4, gc1_4);
    end
`endif
  endtask

  // Transaction-level model: one operation in flight, response due LAT edges after accept.
  task automatic test_random();
    logic        m_last = 1'b1;
    logic        m_idle = 1'b1;
    logic        m_rspv = 1'b0;
    int          m_cnt  = 0;
    logic        m_id   = 1'b0;
    logic [15:0] m_data = '0;
    int          g0 = 0, g1 = 0;
    logic        e0, e1, w;
    logic [20:0] obs, expv;
    do_reset();
    w = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      req0_valid = ($urandom_range(0, 99) < 60);
      req1_valid = ($urandom_range(0, 99) < 60);
      req0_a = 8'($urandom_range(0, 255)); req0_b = 8'($urandom_range(0, 255));
      req1_a = 8'($urandom_range(0, 255)); req1_b = 8'($urandom_range(0, 255));
      rsp_ready = ($urandom_range(0, 99) < 65);
      @(negedge clk);
      e0 = 1'b0; e1 = 1'b0;
      if (m_idle && (req0_valid || req1_valid)) begin
        w  = (req0_valid && req1_valid) ? ~m_last : req1_valid;
        e0 = ~w; e1 = w;
      end
      obs  = {r0_1, r1_1, busy_1, rv_1, rv_1 ? rid_1 : 1'b0, rv_1 ? rd_1 : 16'd0};
      expv = {e0, e1, ~m_idle, m_rspv, m_rspv ? m_id : 1'b0, m_rspv ? m_data : 16'd0};
      n_tests++;
      if (obs !== expv) begin
        n_fail++; $display("FAIL rand_cycle cyc=%0d got=%h want=%h", c, obs, expv);
      end
      if (m_idle) begin
        if (e0 || e1) begin
          m_idle = 1'b0;
          m_cnt  = 1;
          m_last = w;
          m_id   = w;
          m_data = w ? 16'(req1_a) * 16'(req1_b) : 16'(req0_a) * 16'(req0_b);
          if (w) g1++; else g0++;
        end
      end else if (!m_rspv) begin
        m_cnt--;
        if (m_cnt == 0) m_rspv = 1'b1;
      end else if (rsp_ready) begin
        m_rspv = 1'b0;
        m_idle = 1'b1;
      end
    end
`ifdef MUL_ARB_STATS_EN
    n_tests++;
    if ({gc0_1, gc1_1} !== {16'(g0), 16'(g1)}) begin
      n_fail++; $display("FAIL rand_stats got %0d/%0d want %0d/%0d", gc0_1, gc1_1, g0, g1);
    end
`endif
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_max_operands();
    test_zero_identity();
    test_round_robin();
    test_backpressure();
    test_lat4();
    test_reset_mid_busy();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
